// File: rtl/regread_unit.sv
// regread_unit: read side of the 8 x 32-bit register file.
// Fetches two source operands (A, B) for the decode stage. The pair is returned
// registered through a one-entry valid/ready output stage. A load scoreboard stalls
// reads of registers whose memory write-back is still outstanding.
// Optional feature macro: REGREAD_BYPASS_EN
//   defined   - same-cycle dstE/dstM write-back values are forwarded into the operands.
//   undefined - operands come from r0..r7 only; a source written this cycle stalls one cycle.
module regread_unit #(
    parameter int W    = 32,
    parameter int NREG = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      srcA,
    input  logic [3:0]      srcB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    valA,
    output logic [W-1:0]    valB,
    input  logic [W-1:0]    r0,
    input  logic [W-1:0]    r1,
    input  logic [W-1:0]    r2,
    input  logic [W-1:0]    r3,
    input  logic [W-1:0]    r4,
    input  logic [W-1:0]    r5,
    input  logic [W-1:0]    r6,
    input  logic [W-1:0]    r7,
    input  logic [3:0]      dstE,
    input  logic [W-1:0]    valE,
    input  logic [3:0]      dstM,
    input  logic [W-1:0]    valM,
    input  logic            ld_issue,
    input  logic [3:0]      ld_dst,
    output logic [NREG-1:0] busy
);

    localparam int         IDXW    = $clog2(NREG);
    localparam logic [3:0] NREG_ID = 4'(NREG);

    logic [NREG-1:0][W-1:0] regs_s;
    logic                   hazard_a_s;
    logic                   hazard_b_s;
    logic                   hazard_s;
    logic                   accept_s;
    logic [W-1:0]           oper_a_s;
    logic [W-1:0]           oper_b_s;
    logic [NREG-1:0]        busy_next_s;
    logic [NREG-1:0]        busy_r;
    logic                   out_valid_r;
    logic [W-1:0]           val_a_r;
    logic [W-1:0]           val_b_r;

`ifdef REGREAD_BYPASS_EN
    // Newest value of a source: M write-back beats E write-back beats the regfile
    function automatic logic [W-1:0] read_src(
        input logic [3:0]             src,
        input logic [NREG-1:0][W-1:0] regs,
        input logic [3:0]             dst_e,
        input logic [W-1:0]           val_e,
        input logic [3:0]             dst_m,
        input logic [W-1:0]           val_m
    );
        logic [W-1:0] value;
        if (src >= NREG_ID) begin
            value = {W{1'b0}};
        end else if (src == dst_m) begin
            value = val_m;
        end else if (src == dst_e) begin
            value = val_e;
        end else begin
            value = regs[src[IDXW-1:0]];
        end
        return value;
    endfunction

    // A pending load blocks the read unless its write-back lands this cycle
    function automatic logic src_hazard(
        input logic [3:0]      src,
        input logic [NREG-1:0] pend,
        input logic [3:0]      dst_m
    );
        return (src < NREG_ID) && pend[src[IDXW-1:0]] && (src != dst_m);
    endfunction

    assign oper_a_s   = read_src(srcA, regs_s, dstE, valE, dstM, valM);
    assign oper_b_s   = read_src(srcB, regs_s, dstE, valE, dstM, valM);
    assign hazard_a_s = src_hazard(srcA, busy_r, dstM);
    assign hazard_b_s = src_hazard(srcB, busy_r, dstM);
`else
    // Without forwarding the operand always comes straight from the regfile
    function automatic logic [W-1:0] read_src(
        input logic [3:0]             src,
        input logic [NREG-1:0][W-1:0] regs
    );
        logic [W-1:0] value;
        if (src >= NREG_ID) begin
            value = {W{1'b0}};
        end else begin
            value = regs[src[IDXW-1:0]];
        end
        return value;
    endfunction

    // A source being written this cycle (or still pending a load) waits for the regfile
    function automatic logic src_hazard(
        input logic [3:0]      src,
        input logic [NREG-1:0] pend,
        input logic [3:0]      dst_e,
        input logic [3:0]      dst_m
    );
        return (src < NREG_ID) &&
               (pend[src[IDXW-1:0]] || (src == dst_e) || (src == dst_m));
    endfunction

    logic unused_wb_vals_s;

    assign unused_wb_vals_s = ^{valE, valM};
    assign oper_a_s   = read_src(srcA, regs_s);
    assign oper_b_s   = read_src(srcB, regs_s);
    assign hazard_a_s = src_hazard(srcA, busy_r, dstE, dstM);
    assign hazard_b_s = src_hazard(srcB, busy_r, dstE, dstM);
`endif

    assign regs_s    = {r7, r6, r5, r4, r3, r2, r1, r0};
    assign hazard_s  = hazard_a_s || hazard_b_s;
    assign req_ready = (!out_valid_r || out_ready) && !hazard_s;
    assign accept_s  = req_valid && req_ready;

    // Scoreboard update: a newly issued load wins over a same-cycle write-back clear
    always_comb begin
        busy_next_s = busy_r;
        for (int i = 0; i < NREG; i++) begin
            if (ld_issue && (ld_dst == 4'(i))) begin
                busy_next_s[i] = 1'b1;
            end else if (dstM == 4'(i)) begin
                busy_next_s[i] = 1'b0;
            end else begin
                busy_next_s[i] = busy_r[i];
            end
        end
    end

    // Scoreboard register, tracked regardless of the request handshake
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // One-entry output stage: load on accept, drain on take, otherwise hold
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            val_a_r     <= {W{1'b0}};
            val_b_r     <= {W{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            val_a_r     <= oper_a_s;
            val_b_r     <= oper_b_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign valA      = val_a_r;
    assign valB      = val_b_r;
    assign busy      = busy_r;

endmodule
